// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared register-file definitions: data/address widths,
//                register count, the hardwired-zero register index and the
//                writeback entry record carried through the writeback buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fwd_match
//  Description : Combinational youngest-match search over the writeback queue.
//                Entries are walked oldest-to-youngest starting at the head
//                pointer, so the last valid match found is the newest pending
//                value for the address. Address zero never hits.
//  Ports       : i_valid  per-entry valid bits
//                i_rd     per-entry destination register
//                i_data   per-entry result value
//                i_head   index of the oldest entry
//                i_addr   register address being looked up
//                o_hit    a valid entry targets i_addr
//                o_data   data of the youngest such entry, else 0
//  Revision    : 1.0  initial release
// ============================================================================
module wb_fwd_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic [DEPTH-1:0]              i_valid,
    input  logic [DEPTH-1:0][AW-1:0]      i_rd,
    input  logic [DEPTH-1:0][DW-1:0]      i_data,
    input  logic [$clog2(DEPTH)-1:0]      i_head,
    input  logic [AW-1:0]                 i_addr,
    output logic                          o_hit,
    output logic [DW-1:0]                 o_data
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [c_PTR_W-1:0] w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Pointer arithmetic wraps naturally because DEPTH is a power of 2.
            w_idx = i_head + c_PTR_W'(i);
            if (i_valid[w_idx] && (i_rd[w_idx] == i_addr) &&
                (i_addr != AW'(REG_ZERO))) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_buffer
//  Description : Write-side front end of the 32x32 register file. Buffers
//                writeback results in a small in-order queue, drains one entry
//                per cycle onto the regfile write port and offers forwarding
//                of the newest pending value for both read addresses.
//  Ports       : clk, rst                 clock / synchronous active-high reset
//                in_valid/in_ready        producer handshake (ready = !full)
//                in_rd, in_data           destination register and result
//                wb_we, wb_a3, wb_wd3     regfile write port (head entry)
//                a1, a2                   regfile read addresses
//                fwd1_hit/fwd1_data       pending-write lookup for a1
//                fwd2_hit/fwd2_data       pending-write lookup for a2
//                empty, full              queue occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_buffer
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int AW    = regfile_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_data,
    output logic            wb_we,
    output logic [AW-1:0]   wb_a3,
    output logic [XLEN-1:0] wb_wd3,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic            fwd1_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd2_data,
    output logic            empty,
    output logic            full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0]         r_head;
    logic [c_PTR_W-1:0]         r_tail;
    logic [c_CNT_W-1:0]         r_count;
    logic [DEPTH-1:0]           r_valid;
    logic [DEPTH-1:0][AW-1:0]   r_rd;
    logic [DEPTH-1:0][XLEN-1:0] r_data;

    logic      w_empty;
    logic      w_full;
    logic      w_push;
    logic      w_pop;
    wb_entry_t w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));

    // Writes to x0 complete the handshake but are dropped: x0 is hardwired.
    assign w_push  = in_valid && !w_full && (in_rd != AW'(REG_ZERO));
    // Head drains every cycle the queue holds something.
    assign w_pop   = !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_rd[r_tail]    <= in_rd;
                r_data[r_tail]  <= in_data;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_PTR_W'(1);
            end
            // Push and pop never target the same slot: a pop needs a
            // non-empty queue, where head != tail unless the queue is full,
            // and a full queue refuses pushes.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head.rd   = r_rd[r_head];
    assign w_head.data = r_data[r_head];

    // The regfile must not be written in a reset cycle, even though the
    // head entry is still visible until the reset edge clears the queue.
    assign wb_we    = w_pop && !rst;
    assign wb_a3    = w_empty ? '0 : w_head.rd;
    assign wb_wd3   = w_empty ? '0 : w_head.data;

    assign in_ready = !w_full;
    assign empty    = w_empty;
    assign full     = w_full;

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .DW    (XLEN),
        .AW    (AW)
    ) u_fwd1 (
        .i_valid (r_valid),
        .i_rd    (r_rd),
        .i_data  (r_data),
        .i_head  (r_head),
        .i_addr  (a1),
        .o_hit   (fwd1_hit),
        .o_data  (fwd1_data)
    );

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .DW    (XLEN),
        .AW    (AW)
    ) u_fwd2 (
        .i_valid (r_valid),
        .i_rd    (r_rd),
        .i_data  (r_data),
        .i_head  (r_head),
        .i_addr  (a2),
        .o_hit   (fwd2_hit),
        .o_data  (fwd2_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_buffer
//  Description : Self-checking bench for regfile_wb_buffer: directed vector
//                table, a hand-written back-to-back sequence and randomized
//                traffic compared against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rd;
    logic [XLEN-1:0] in_data;
    logic            wb_we;
    logic [AW-1:0]   wb_a3;
    logic [XLEN-1:0] wb_wd3;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic            fwd1_hit;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd2_data;
    logic            empty;
    logic            full;

    always #5 clk = ~clk;

    regfile_wb_buffer #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .wb_we     (wb_we),
        .wb_a3     (wb_a3),
        .wb_wd3    (wb_wd3),
        .a1        (a1),
        .a2        (a2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .empty     (empty),
        .full      (full)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, v;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [4:0]  a1, a2;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        emp, ful, rdy, h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;

    vec_t tv[20];

    function automatic vec_t mk(
        input logic r, input logic v, input logic [4:0] rd, input logic [31:0] d,
        input logic [4:0] x1, input logic [4:0] x2,
        input logic we, input logic [4:0] a3, input logic [31:0] wd,
        input logic emp, input logic ful, input logic rdy,
        input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2);
        vec_t t;
        t.rst = r; t.v = v; t.rd = rd; t.d = d; t.a1 = x1; t.a2 = x2;
        t.we = we; t.a3 = a3; t.wd = wd; t.emp = emp; t.ful = ful; t.rdy = rdy;
        t.h1 = h1; t.d1 = d1; t.h2 = h2; t.d2 = d2;
        return t;
    endfunction

    // Drive one cycle's inputs right after a posedge.
    task automatic drive(input logic r, input logic v, input logic [4:0] rd,
                         input logic [31:0] d, input logic [4:0] x1, input logic [4:0] x2);
        rst = r; in_valid = v; in_rd = rd; in_data = d; a1 = x1; a2 = x2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];

    task automatic model_check(input string tag);
        logic        e_hit1, e_hit2;
        logic [31:0] e_d1, e_d2;
        e_hit1 = 1'b0; e_d1 = '0; e_hit2 = 1'b0; e_d2 = '0;
        // Youngest match wins: scan oldest to newest, keep the last hit.
        foreach (mq[j]) begin
            if (a1 != 0 && mq[j].rd == a1) begin e_hit1 = 1'b1; e_d1 = mq[j].data; end
            if (a2 != 0 && mq[j].rd == a2) begin e_hit2 = 1'b1; e_d2 = mq[j].data; end
        end
        chk({tag, " wb_we"},  {31'd0, wb_we},    {31'd0, (mq.size() > 0) && !rst});
        chk({tag, " wb_a3"},  {27'd0, wb_a3},    (mq.size() > 0) ? {27'd0, mq[0].rd} : 32'd0);
        chk({tag, " wb_wd3"}, wb_wd3,            (mq.size() > 0) ? mq[0].data : 32'd0);
        chk({tag, " empty"},  {31'd0, empty},    {31'd0, mq.size() == 0});
        chk({tag, " full"},   {31'd0, full},     {31'd0, mq.size() == DEPTH});
        chk({tag, " ready"},  {31'd0, in_ready}, {31'd0, mq.size() < DEPTH});
        chk({tag, " hit1"},   {31'd0, fwd1_hit}, {31'd0, e_hit1});
        chk({tag, " data1"},  fwd1_data,         e_d1);
        chk({tag, " hit2"},   {31'd0, fwd2_hit}, {31'd0, e_hit2});
        chk({tag, " data2"},  fwd2_data,         e_d2);
    endtask

    task automatic model_edge();
        logic can_push;
        can_push = in_valid && (mq.size() < DEPTH) && (in_rd != 0);
        if (rst) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (can_push) mq.push_back('{rd: in_rd, data: in_data});
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        tv[0]  = mk(1,0,0,32'h0,       0,0, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[1]  = mk(0,1,5,32'hDEADBEEF,5,0, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[2]  = mk(0,0,0,32'h0,       5,0, 1,5,32'hDEADBEEF, 0,0,1, 1,32'hDEADBEEF, 0,32'h0);
        tv[3]  = mk(0,0,0,32'h0,       5,0, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[4]  = mk(0,1,1,32'h11,      1,4, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[5]  = mk(0,1,2,32'h22,      1,4, 1,1,32'h11,       0,0,1, 1,32'h11,       0,32'h0);
        tv[6]  = mk(0,1,3,32'h33,      1,4, 1,2,32'h22,       0,0,1, 0,32'h0,        0,32'h0);
        tv[7]  = mk(0,1,4,32'h44,      1,4, 1,3,32'h33,       0,0,1, 0,32'h0,        0,32'h0);
        tv[8]  = mk(0,0,0,32'h0,       1,4, 1,4,32'h44,       0,0,1, 0,32'h0,        1,32'h44);
        tv[9]  = mk(0,0,0,32'h0,       1,4, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[10] = mk(0,1,3,32'h1,       3,3, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[11] = mk(0,1,3,32'h2,       3,3, 1,3,32'h1,        0,0,1, 1,32'h1,        1,32'h1);
        tv[12] = mk(0,0,0,32'h0,       3,3, 1,3,32'h2,        0,0,1, 1,32'h2,        1,32'h2);
        tv[13] = mk(0,0,0,32'h0,       3,3, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[14] = mk(0,1,0,32'hFFFF,    0,0, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[15] = mk(0,0,0,32'h0,       0,0, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[16] = mk(0,1,7,32'h77,      7,0, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[17] = mk(1,1,9,32'h99,      7,9, 0,7,32'h77,       0,0,1, 1,32'h77,       0,32'h0);
        tv[18] = mk(0,0,0,32'h0,       7,9, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);
        tv[19] = mk(0,0,0,32'h0,       7,9, 0,0,32'h0,        1,0,1, 0,32'h0,        0,32'h0);

        // Two reset edges before anything is observed.
        next_cycle();
        next_cycle();

        for (int i = 0; i < 20; i++) begin
            drive(tv[i].rst, tv[i].v, tv[i].rd, tv[i].d, tv[i].a1, tv[i].a2);
            @(negedge clk);
            chk($sformatf("v%0d wb_we", i),  {31'd0, wb_we},    {31'd0, tv[i].we});
            chk($sformatf("v%0d wb_a3", i),  {27'd0, wb_a3},    {27'd0, tv[i].a3});
            chk($sformatf("v%0d wb_wd3", i), wb_wd3,            tv[i].wd);
            chk($sformatf("v%0d empty", i),  {31'd0, empty},    {31'd0, tv[i].emp});
            chk($sformatf("v%0d full", i),   {31'd0, full},     {31'd0, tv[i].ful});
            chk($sformatf("v%0d ready", i),  {31'd0, in_ready}, {31'd0, tv[i].rdy});
            chk($sformatf("v%0d hit1", i),   {31'd0, fwd1_hit}, {31'd0, tv[i].h1});
            chk($sformatf("v%0d data1", i),  fwd1_data,         tv[i].d1);
            chk($sformatf("v%0d hit2", i),   {31'd0, fwd2_hit}, {31'd0, tv[i].h2});
            chk($sformatf("v%0d data2", i),  fwd2_data,         tv[i].d2);
            next_cycle();
        end

        // Hand sequence: a stream of duplicate-rd pushes, each one written on
        // the cycle after it was pushed, in order, never filling the queue.
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, (k < 5), 5'd6, 32'hA000 + k, 5'd6, 5'd0);
            @(negedge clk);
            chk($sformatf("dup%0d wb_we", k),  {31'd0, wb_we}, {31'd0, k > 0});
            chk($sformatf("dup%0d wb_wd3", k), wb_wd3, (k > 0) ? 32'hA000 + k - 1 : 32'd0);
            chk($sformatf("dup%0d data1", k),  fwd1_data, (k > 0) ? 32'hA000 + k - 1 : 32'd0);
            chk($sformatf("dup%0d full", k),   {31'd0, full}, 32'd0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        next_cycle();

        // Randomized traffic against the queue model.
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            @(negedge clk);
            model_check($sformatf("rnd%0d", c));
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
